// File: rtl/fp29i_to_fp16_pack.sv
// rtl/fp29i_to_fp16_pack.sv - FP29i unified result to IEEE FP16 renormalize/round/pack pipeline
//
// Purpose: two-stage formatter behind the FIR FP ALU. Stage 1 normalizes the
// 22-bit mantissa and rebiases the exponent; stage 2 extracts sig/guard/sticky,
// rounds to nearest-even, handles subnormal/overflow and packs FP16.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   din_uni_y_sgn/exp/man_dn  unified input word (sign, 6b exp, 22b mantissa)
//   din_valid, din_ready   input handshake
//   dout_fp16, dout_valid, dout_ready  output handshake
//   flag_clr               clear sticky flags (a coincident event wins)
//   flag_ovf/unf/inx       sticky overflow / underflow / inexact
module fp29i_to_fp16_pack #(
  parameter bit SAT_OVF      = 1'b0,
  parameter int IN_EXP_BIAS  = 31,
  parameter int OUT_EXP_BIAS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din_uni_y_sgn,
  input  logic [5:0]  din_uni_y_exp,
  input  logic [21:0] din_uni_y_man_dn,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [15:0] dout_fp16,
  output logic        dout_valid,
  input  logic        dout_ready,
  input  logic        flag_clr,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inx
);

  localparam int EW = 10;
  localparam logic signed [EW-1:0] BIAS_ADJ = EW'(OUT_EXP_BIAS - IN_EXP_BIAS);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(31);
  localparam logic signed [EW-1:0] SH_MAX   = EW'(23);

  logic              r_s1_valid;
  logic              r_s1_sgn;
  logic              r_s1_zero;
  logic [21:0]       r_s1_man;
  logic signed [EW-1:0] r_s1_e16;
  logic              r_dout_valid;
  logic [15:0]       r_dout_fp16;
  logic              r_flag_ovf;
  logic              r_flag_unf;
  logic              r_flag_inx;

  logic              w_stall;
  logic              w_xfer2;
  logic [4:0]        w_lz;
  logic              w_zero;
  logic [21:0]       w_man_n;
  logic signed [EW-1:0] w_e16;

  assign w_stall   = r_dout_valid & ~dout_ready;
  assign din_ready = ~w_stall;
  assign w_xfer2   = ~w_stall & r_s1_valid;

  // Leading-zero count: the highest set bit is visited last and wins.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < 22; i++) begin
      if (din_uni_y_man_dn[i]) w_lz = 5'(21 - i);
    end
  end

  assign w_zero  = (din_uni_y_man_dn == '0);
  assign w_man_n = din_uni_y_man_dn << w_lz;
  assign w_e16   = $signed({{(EW-6){1'b0}}, din_uni_y_exp})
                 - $signed({{(EW-5){1'b0}}, w_lz}) + BIAS_ADJ;

  // Stage 2: subnormal shift, rounding and packing from the stage-1 register.
  logic                 w_sub;
  logic signed [EW-1:0] w_sh_full;
  logic [4:0]           w_sh;
  logic [44:0]          w_ext;
  logic [10:0]          w_sig;
  logic                 w_g;
  logic                 w_s;
  logic                 w_rnd;
  logic [11:0]          w_sum;
  logic signed [EW-1:0] w_exp_rnd;
  logic                 w_ovf;
  logic                 w_inx;
  logic                 w_unf;
  logic [15:0]          w_fp16;

  assign w_sub     = (r_s1_e16 < EXP_ONE);
  assign w_sh_full = EXP_ONE - r_s1_e16;

  // Shifts of 23 or more push every mantissa bit below the guard position,
  // so clamping keeps the shifter small without changing sig/G/S.
  always_comb begin
    w_sh = '0;
    if (w_sub) w_sh = (w_sh_full > SH_MAX) ? 5'd23 : w_sh_full[4:0];
  end

  // 23 extension bits catch everything shifted out so it folds into sticky.
  assign w_ext = {r_s1_man, 23'b0} >> w_sh;
  assign w_sig = w_ext[44:34];
  assign w_g   = w_ext[33];
  assign w_s   = |w_ext[32:0];
  assign w_rnd = w_g & (w_s | w_sig[0]);
  assign w_sum = {1'b0, w_sig} + {11'b0, w_rnd};

  // Normal: carry out of bit 10 bumps the exponent (fraction is already 0).
  // Subnormal: rounding into bit 10 yields exponent field 1.
  assign w_exp_rnd = w_sub ? $signed({{(EW-1){1'b0}}, w_sum[10]})
                           : r_s1_e16 + $signed({{(EW-1){1'b0}}, w_sum[11]});

  assign w_ovf = ~r_s1_zero & (w_exp_rnd >= EXP_MAX);
  assign w_inx = ~r_s1_zero & (w_g | w_s | w_ovf);
  assign w_unf = ~r_s1_zero & w_inx & (w_exp_rnd == '0);

  always_comb begin
    w_fp16 = {r_s1_sgn, w_exp_rnd[4:0], w_sum[9:0]};
    if (r_s1_zero) begin
      w_fp16 = {r_s1_sgn, 15'h0000};
    end else if (w_ovf) begin
      w_fp16 = SAT_OVF ? {r_s1_sgn, 15'h7BFF} : {r_s1_sgn, 15'h7C00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sgn     <= 1'b0;
      r_s1_zero    <= 1'b0;
      r_s1_man     <= '0;
      r_s1_e16     <= '0;
      r_dout_valid <= 1'b0;
      r_dout_fp16  <= 16'h0000;
      r_flag_ovf   <= 1'b0;
      r_flag_unf   <= 1'b0;
      r_flag_inx   <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_s1_valid   <= din_valid;
        r_s1_sgn     <= din_uni_y_sgn;
        r_s1_zero    <= w_zero;
        r_s1_man     <= w_man_n;
        r_s1_e16     <= w_e16;
        r_dout_valid <= r_s1_valid;
        if (r_s1_valid) r_dout_fp16 <= w_fp16;
      end
      r_flag_ovf <= (r_flag_ovf & ~flag_clr) | (w_xfer2 & w_ovf);
      r_flag_unf <= (r_flag_unf & ~flag_clr) | (w_xfer2 & w_unf);
      r_flag_inx <= (r_flag_inx & ~flag_clr) | (w_xfer2 & w_inx);
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout_fp16  = r_dout_fp16;
  assign flag_ovf   = r_flag_ovf;
  assign flag_unf   = r_flag_unf;
  assign flag_inx   = r_flag_inx;

endmodule

// File: tb/tb_fp29i_to_fp16_pack.sv
// tb/tb_fp29i_to_fp16_pack.sv - self-checking bench for fp29i_to_fp16_pack
module tb_fp29i_to_fp16_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_uni_y_sgn;
  logic [5:0]  din_uni_y_exp;
  logic [21:0] din_uni_y_man_dn;
  logic        din_valid;
  logic        dout_ready;
  logic        flag_clr;

  logic        din_ready;
  logic [15:0] dout_fp16;
  logic        dout_valid;
  logic        flag_ovf, flag_unf, flag_inx;

  logic        s_din_ready;
  logic [15:0] s_dout_fp16;
  logic        s_dout_valid;
  logic        s_flag_ovf, s_flag_unf, s_flag_inx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp29i_to_fp16_pack #(.SAT_OVF(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .din_uni_y_sgn(din_uni_y_sgn), .din_uni_y_exp(din_uni_y_exp),
    .din_uni_y_man_dn(din_uni_y_man_dn), .din_valid(din_valid),
    .din_ready(din_ready), .dout_fp16(dout_fp16), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .flag_clr(flag_clr),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
  );

  fp29i_to_fp16_pack #(.SAT_OVF(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .din_uni_y_sgn(din_uni_y_sgn), .din_uni_y_exp(din_uni_y_exp),
    .din_uni_y_man_dn(din_uni_y_man_dn), .din_valid(din_valid),
    .din_ready(s_din_ready), .dout_fp16(s_dout_fp16), .dout_valid(s_dout_valid),
    .dout_ready(dout_ready), .flag_clr(flag_clr),
    .flag_ovf(s_flag_ovf), .flag_unf(s_flag_unf), .flag_inx(s_flag_inx)
  );

  typedef struct packed {
    logic [15:0] r0;
    logic [15:0] r1;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  function automatic real pow2(input int k);
    real p = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) p = p * 2.0;
    else        for (int i = 0; i < -k; i++) p = p / 2.0;
    return p;
  endfunction

  // Reference: exact real value, then quantize to the FP16 grid with
  // round-half-even; all values involved are exactly representable in double.
  function automatic exp_t ref_model(input logic s, input logic [5:0] e, input logic [21:0] m);
    exp_t o;
    real  v, x, n, fr;
    int   ex, eq, r, ef, fv;
    o = '0;
    if (m == 22'd0) begin
      o.r0 = {s, 15'h0000};
      o.r1 = o.r0;
      return o;
    end
    v = real'(m) * pow2(int'(e) - 31 - 21);
    x = v; ex = 0;
    while (x >= 2.0) begin x = x / 2.0; ex++; end
    while (x < 1.0)  begin x = x * 2.0; ex--; end
    eq = (ex < -14) ? -14 : ex;
    n  = v / pow2(eq - 10);
    r  = $rtoi(n);
    fr = n - real'(r);
    o.inx = (fr != 0.0);
    if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r++;
    if (r >= 2048) begin r = r / 2; eq++; end
    ef = (r >= 1024) ? eq + 15 : 0;
    if (ef >= 31) begin
      o.ovf = 1'b1; o.inx = 1'b1;
      o.r0 = {s, 15'h7C00};
      o.r1 = {s, 15'h7BFF};
    end else begin
      fv = (r >= 1024) ? r - 1024 : r;
      o.r0 = {s, 5'(ef), 10'(fv)};
      o.r1 = o.r0;
      o.unf = (ef == 0) && o.inx;
    end
    return o;
  endfunction

  localparam int NDIR = 10;
  logic        d_sgn [NDIR] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  logic [5:0]  d_exp [NDIR] = '{31, 31, 31, 46, 16, 2, 33, 31, 50, 16};
  logic [21:0] d_man [NDIR] = '{22'h200000, 22'h200400, 22'h200C00, 22'h3FFFFF, 22'h200000,
                                22'h200000, 22'h080000, 22'h000000, 22'h200000, 22'h3FFFFF};
  logic [15:0] d_r0  [NDIR] = '{16'h3C00, 16'h3C00, 16'h3C02, 16'h7C00, 16'h0200,
                                16'h0000, 16'h3C00, 16'h8000, 16'hFC00, 16'h0400};
  logic [15:0] d_r1  [NDIR] = '{16'h3C00, 16'h3C00, 16'h3C02, 16'h7BFF, 16'h0200,
                                16'h0000, 16'h3C00, 16'h8000, 16'hFBFF, 16'h0400};
  logic [2:0]  d_flg [NDIR] = '{3'b000, 3'b001, 3'b001, 3'b101, 3'b000,
                                3'b011, 3'b000, 3'b000, 3'b101, 3'b001};

  task automatic idle_clear();
    din_valid = 1'b0; dout_ready = 1'b1; flag_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 flag_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 1'b0; dout_ready = 1'b1; flag_clr = 1'b0;
    din_uni_y_sgn = 1'b0; din_uni_y_exp = '0; din_uni_y_man_dn = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dout_valid); end
    total++; if (dout_fp16 !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", dout_fp16); end
    total++; if ({flag_ovf, flag_unf, flag_inx} !== 3'b000) begin bad++;
      $display("FAIL reset_flags got=%b want=000", {flag_ovf, flag_unf, flag_inx}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL reset_din_ready got=%b want=1", din_ready); end
  endtask

  task automatic test_directed();
    for (int i = 0; i < NDIR; i++) begin
      idle_clear();
      din_uni_y_sgn = d_sgn[i]; din_uni_y_exp = d_exp[i]; din_uni_y_man_dn = d_man[i];
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid got=%b want=0", i, dout_valid); end
      @(posedge clk); #1;
      total++; if (dout_valid !== 1'b1 || dout_fp16 !== d_r0[i]) begin bad++;
        $display("FAIL dir%0d_data got valid=%b %h want valid=1 %h", i, dout_valid, dout_fp16, d_r0[i]); end
      total++; if (s_dout_fp16 !== d_r1[i]) begin bad++;
        $display("FAIL dir%0d_sat_data got=%h want=%h", i, s_dout_fp16, d_r1[i]); end
      total++; if ({flag_ovf, flag_unf, flag_inx} !== d_flg[i]) begin bad++;
        $display("FAIL dir%0d_flags got=%b want=%b", i, {flag_ovf, flag_unf, flag_inx}, d_flg[i]); end
    end
  endtask

  task automatic test_flags();
    idle_clear();
    din_uni_y_sgn = 1'b0; din_uni_y_exp = 6'd31; din_uni_y_man_dn = 22'h200400;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; flag_clr = 1'b1;
    @(posedge clk); #1;
    total++; if (flag_inx !== 1'b1 || dout_fp16 !== 16'h3C00) begin bad++;
      $display("FAIL flag_clr_vs_event got inx=%b %h want inx=1 3c00", flag_inx, dout_fp16); end
    @(posedge clk); #1;
    total++; if (flag_inx !== 1'b0) begin bad++; $display("FAIL flag_clr got inx=%b want=0", flag_inx); end
    flag_clr = 1'b0;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic acc_in, acc_out, hold;
    logic [15:0] pd0, pd1;
    logic mo = 1'b0, mu = 1'b0, mi = 1'b0;
    idle_clear();
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din_uni_y_sgn = 1'($urandom);
        din_uni_y_exp = 6'($urandom_range(0, 63));
        din_uni_y_man_dn = 22'($urandom) >> $urandom_range(0, 21);
        if ($urandom_range(0, 15) == 0) din_uni_y_man_dn = '0;
        dout_ready = ($urandom_range(0, 9) < 7);
      end else begin
        din_valid = 1'b0; dout_ready = 1'b1;
      end
      #1;
      total++; if (din_ready !== ~(dout_valid & ~dout_ready)) begin bad++;
        $display("FAIL rnd_din_ready cyc=%0d got=%b want=%b", cyc, din_ready, ~(dout_valid & ~dout_ready)); end
      acc_in  = din_valid & din_ready;
      acc_out = dout_valid & dout_ready;
      hold    = dout_valid & ~dout_ready;
      pd0 = dout_fp16; pd1 = s_dout_fp16;
      @(posedge clk); #1;
      if (acc_in) begin
        e = ref_model(din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn);
        q.push_back(e);
        mo |= e.ovf; mu |= e.unf; mi |= e.inx;
      end
      if (acc_out) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_extra_output cyc=%0d got=%h want=none", cyc, pd0);
        end else begin
          e = q.pop_front();
          if (pd0 !== e.r0 || pd1 !== e.r1) begin bad++;
            $display("FAIL rnd_data cyc=%0d got=%h/%h want=%h/%h", cyc, pd0, pd1, e.r0, e.r1); end
        end
      end
      if (hold) begin
        total++; if (dout_valid !== 1'b1 || dout_fp16 !== pd0) begin bad++;
          $display("FAIL rnd_hold cyc=%0d got valid=%b %h want valid=1 %h", cyc, dout_valid, dout_fp16, pd0); end
      end
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_missing got=%0d left want=0", q.size()); end
    total++; if ({flag_ovf, flag_unf, flag_inx} !== {mo, mu, mi}) begin bad++;
      $display("FAIL rnd_flags got=%b want=%b", {flag_ovf, flag_unf, flag_inx}, {mo, mu, mi}); end
  endtask

  task automatic test_back_to_back();
    logic        b_sgn [4] = '{0, 0, 1, 0};
    logic [5:0]  b_exp [4] = '{31, 31, 40, 20};
    logic [21:0] b_man [4] = '{22'h200000, 22'h200C00, 22'h123456, 22'h000FFF};
    logic [15:0] got [$];
    exp_t e;
    int idx = 0;
    logic seen_stall = 1'b0;
    logic acc_in, acc_out, hold;
    logic [15:0] pd;
    idle_clear();
    for (int cyc = 0; cyc < 20; cyc++) begin
      din_valid = (idx < 4);
      if (idx < 4) begin
        din_uni_y_sgn = b_sgn[idx]; din_uni_y_exp = b_exp[idx]; din_uni_y_man_dn = b_man[idx];
      end
      dout_ready = (cyc >= 5);
      #1;
      if (!din_ready) seen_stall = 1'b1;
      acc_in = din_valid & din_ready;
      acc_out = dout_valid & dout_ready;
      hold = dout_valid & ~dout_ready;
      pd = dout_fp16;
      @(posedge clk); #1;
      if (acc_in) idx++;
      if (acc_out) got.push_back(pd);
      if (hold) begin
        total++; if (dout_valid !== 1'b1 || dout_fp16 !== pd) begin bad++;
          $display("FAIL b2b_hold cyc=%0d got valid=%b %h want valid=1 %h", cyc, dout_valid, dout_fp16, pd); end
      end
    end
    total++; if (seen_stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got din_ready_drop=%b want=1", seen_stall); end
    total++; if (got.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      e = ref_model(b_sgn[i], b_exp[i], b_man[i]);
      total++; if (got[i] !== e.r0) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", i, got[i], e.r0); end
    end
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    idle_clear();
    dout_ready = 1'b1;
    din_uni_y_sgn = 1'b0; din_uni_y_exp = 6'd31; din_uni_y_man_dn = 22'h200400; din_valid = 1'b1;
    @(posedge clk); #1;
    din_uni_y_man_dn = 22'h200C00;
    @(posedge clk); #1;
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre_valid got=%b want=1", dout_valid); end
    din_uni_y_man_dn = 22'h300000;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; din_valid = 1'b0;
    total++; if (dout_valid !== 1'b0 || dout_fp16 !== 16'h0000) begin bad++;
      $display("FAIL mrst_clear got valid=%b %h want valid=0 0000", dout_valid, dout_fp16); end
    total++; if (flag_inx !== 1'b0) begin bad++; $display("FAIL mrst_flags got inx=%b want=0", flag_inx); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dout_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL mrst_stale got=%0d want=0", stale); end
    total++; if (din_ready !== 1'b1) begin bad++; $display("FAIL mrst_din_ready got=%b want=1", din_ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flags();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp29i_to_fp16_pack.md
Name: fp29i_to_fp16_pack

Overview:
- Output formatter directly downstream of the FIR FP ALU.
- Takes the unified FP29i result (sign, 6-bit exp, 22-bit left-aligned mantissa), renormalizes it, rounds it to nearest-even and packs it into IEEE FP16 for the FIR output port.
- Two-stage pipeline with valid/ready handshakes on both sides and backpressure stall.
- Sticky exception flags for overflow, underflow and inexact.

Parameters:
- SAT_OVF, 0: 1 = overflow saturates to ±0x7BFF; 0 = overflow produces ±Inf (0x7C00).
- IN_EXP_BIAS, 31: bias of the unified 6-bit exponent.
- OUT_EXP_BIAS, 15: bias of the FP16 exponent.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- din_uni_y_sgn  input  1  sign
- din_uni_y_exp  input  6  unified exponent
- din_uni_y_man_dn  input  22  mantissa; bit 21 is the integer bit, not necessarily normalized
- din_valid  input  1  input word valid
- din_ready  output  1  block can accept this cycle
- dout_fp16  output  16  packed FP16 result
- dout_valid  output  1  dout_fp16 valid
- dout_ready  input  1  consumer accepts
- flag_clr  input  1  clear sticky flags
- flag_ovf  output  1  sticky: overflow occurred
- flag_unf  output  1  sticky: tiny nonzero result was inexact (subnormal or flushed to zero)
- flag_inx  output  1  sticky: any rounding loss

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled at the clk rising edge.
- Reset clears all stage valids, dout_valid, dout_fp16 (to 0x0000) and all flags. din_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation discards in-flight words. No output is produced for them.
- Value encoded by the input: (-1)^s * man * 2^(exp - IN_EXP_BIAS - 21).
- Handshake:
  - A transfer happens when valid & ready are both high at the clock edge.
  - stall = dout_valid & ~dout_ready.
  - din_ready = ~stall.
  - While stalled, both stages and the output register hold their values. No data is lost or duplicated, and order is preserved.
  - dout_fp16 is stable while dout_valid & ~dout_ready.
- Latency: exactly 2 cycles from input transfer to dout_valid when there is no stall. Throughput is 1 word/cycle.
- Stage 1 (register at its output):
  - lz = leading-zero count of man, 0..21. If man==0, the result is flagged zero.
  - man_n = man << lz.
  - exp_n = exp - lz, signed, 8 bits.
  - e16 = exp_n - IN_EXP_BIAS + OUT_EXP_BIAS, signed.
- Stage 2 (registered to dout):
  - zero: output {s, 15'b0}; no flags.
  - Normal (e16 >= 1):
    - sig = man_n[21:11], guard G = man_n[10], sticky S = |man_n[9:0].
  - Subnormal (e16 <= 0):
    - sh = 1 - e16. The significand {man_n} is right-shifted by sh before extracting sig/G/S.
    - Bits shifted out OR into S.
    - sh >= 13 means sig = 0 and G = 0, with S = |man_n.
    - The exponent field is 0.
  - Rounding:
    - Round up iff G & (S | sig[0]).
    - A carry out of the 11-bit significand increments the exponent, and the fraction becomes 0.
    - A subnormal rounding into bit 10 becomes exponent field 1.
  - Overflow: final e16 >= 31 gives Inf or saturation per SAT_OVF, and sets flag_ovf and flag_inx.
  - Flags:
    - inexact = G | S.
    - unf is set when the result is subnormal or zero after rounding AND inexact.
    - Flags update only when the stage-2 word is transferred into the output register.
- Flag clearing: flag_clr clears the flags the same cycle. If an event coincides with flag_clr, the event wins and the flag is set.

Test Plan:
- exp=31, man=0x200000, sgn=0, dout_ready=1 -> dout_fp16=0x3C00 exactly 2 cycles after transfer; no flags.
- exp=31, man=0x200400 (tie, LSB 0) -> 0x3C00 with flag_inx=1. Then man=0x200C00 (tie, LSB 1) -> 0x3C02.
- exp=46, man=0x3FFFFF -> rounding carry gives e16=31 -> 0x7C00, flag_ovf=1, flag_inx=1. With SAT_OVF=1 -> 0x7BFF.
- Subnormal and underflow:
  - exp=16, man=0x200000 -> 0x0200, no flags.
  - exp=2, man=0x200000 -> 0x0000, flag_unf=1, flag_inx=1.
- Normalization and zero:
  - Unnormalized exp=33, man=0x080000 -> 0x3C00.
  - sgn=1, man=0 -> 0x8000, no flags.
- Backpressure: stream 4 words back-to-back with dout_ready=0 for 3 cycles -> din_ready drops, and all 4 outputs appear in order without loss or duplication. Asserting rst_n=0 mid-stream leaves dout_valid=0 the next cycle, with no stale outputs afterwards.
